// File: rtl/mem_arbiter.sv
// Two-port-to-one memory arbiter: instruction fetch and data ports share one
// single-ported memory, data has priority with a bounded streak against fetch.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic                i_gnt_o,
  output logic                i_rvalid_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                arb_en, d_win, i_win;

  // Arbitration window: idle, or the cycle the outstanding response returns.
  always_comb begin
    arb_en = (state_q == IDLE) || ((state_q == WAIT) && mem_rvalid_i);
    d_win  = arb_en && d_req_i && !(i_req_i && (streak_q == STREAK_MAX));
    i_win  = arb_en && i_req_i && !d_win;
  end

  // Next-state, owner and streak logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    case (state_q)
      IDLE:    if (d_win || i_win) state_d = REQ;
      REQ:     if (mem_gnt_i) state_d = WAIT;
      WAIT:    if (mem_rvalid_i) state_d = (d_win || i_win) ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    if (d_win) begin
      owner_d = OWN_D;
      if (!i_req_i)                    streak_d = '0;
      else if (streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
    end else if (i_win) begin
      owner_d  = OWN_I;
      streak_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_I;
      streak_q    <= '0;
      mem_req_o   <= 1'b0;
      busy_o      <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      mem_req_o <= (state_d == REQ);
      busy_o    <= (state_d != IDLE);
      if (d_win) begin
        mem_we_o    <= d_we_i;
        mem_be_o    <= d_be_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
      end else if (i_win) begin
        mem_we_o    <= 1'b0;
        mem_be_o    <= {BE_W{1'b1}};
        mem_addr_o  <= i_addr_i;
        mem_wdata_o <= '0;
      end
    end
  end

  // Handshakes and read data are steered to the current owner only.
  always_comb begin
    i_gnt_o    = (state_q == REQ)  && mem_gnt_i    && (owner_q == OWN_I);
    d_gnt_o    = (state_q == REQ)  && mem_gnt_i    && (owner_q == OWN_D);
    i_rvalid_o = (state_q == WAIT) && mem_rvalid_i && (owner_q == OWN_I);
    d_rvalid_o = (state_q == WAIT) && mem_rvalid_i && (owner_q == OWN_D);
    i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
    d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;
  end

endmodule
